heading_tracker: RTL and testbench

HEADING_TRACKER -- requirements
Module: heading_tracker

---
 rtl/heading_tracker.sv | 183 ++++++++++++++++++
 tb/tb_heading_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heading_tracker.sv
`default_nettype none
// ============================================================================
// Module   : heading_tracker
// Purpose  : Tracks a discrete compass heading that rotates one step at a
//            time, at a fixed number of clock cycles per step. Accepts step
//            CW / step CCW / reverse / load commands over a valid/ready
//            handshake, supports abort of an in-progress rotation, and keeps
//            a saturating count of completed steps.
// Ports    : clockc3      - clock, rising-edge active
//            reset        - asynchronous, active-high reset
//            cmd_valid    - command request
//            cmd_ready    - command can be accepted (IDLE only)
//            cmd_op       - 00 CW, 01 CCW, 10 reverse, 11 load heading
//            cmd_steps    - step count for CW/CCW
//            cmd_heading  - target heading for load
//            abort        - stop an in-progress rotation
//            heading      - current heading index (0 = North, +1 = CW)
//            heading_code - legacy 3-bit code (4 headings only, else 000)
//            busy         - rotation in progress
//            done         - one-cycle completion pulse
//            aborted      - qualifies done: command ended by abort
//            turn_count   - saturating count of completed steps
// Revision : 1.0 - initial release
// ============================================================================
module heading_tracker #(
    parameter int N_DIR       = 4,
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 8,
    localparam int HW         = $clog2(N_DIR)
) (
    input  logic             clockc3,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [HW-1:0]    cmd_steps,
    input  logic [HW-1:0]    cmd_heading,
    input  logic             abort,
    output logic [HW-1:0]    heading,
    output logic [2:0]       heading_code,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] turn_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_CW   = 2'b00;
    localparam logic [1:0] OP_CCW  = 2'b01;
    localparam logic [1:0] OP_REV  = 2'b10;

    localparam logic [7:0]       TMR_LAST  = 8'(STEP_CYCLES - 1);
    localparam logic [HW-1:0]    HALF_TURN = HW'(N_DIR / 2);
    localparam logic [HW-1:0]    STEP_ONE  = HW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_q,      state_d;
    logic [HW-1:0]    heading_q,    heading_d;
    logic [7:0]       timer_q,      timer_d;
    logic [HW-1:0]    remaining_q,  remaining_d;
    logic             ccw_q,        ccw_d;
    logic [CNT_W-1:0] turn_count_q, turn_count_d;
    logic             aborted_q,    aborted_d;

    always_comb begin
        state_d      = state_q;
        heading_d    = heading_q;
        timer_d      = timer_q;
        remaining_d  = remaining_q;
        ccw_d        = ccw_q;
        turn_count_d = turn_count_q;
        aborted_d    = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    timer_d   = 8'd0;
                    aborted_d = 1'b0;
                    case (cmd_op)
                        OP_CW, OP_CCW: begin
                            ccw_d       = (cmd_op == OP_CCW);
                            remaining_d = cmd_steps;
                            state_d     = (cmd_steps != '0) ? S_TURN : S_DONE;
                        end
                        OP_REV: begin
                            ccw_d       = 1'b0;
                            remaining_d = HALF_TURN;
                            state_d     = S_TURN;
                        end
                        default: begin
                            heading_d = cmd_heading;
                            state_d   = S_DONE;
                        end
                    endcase
                end
            end

            S_TURN: begin
                if (timer_q == TMR_LAST) begin
                    // Heading width equals log2(N_DIR), so natural
                    // overflow/underflow gives the modular wrap.
                    timer_d     = 8'd0;
                    heading_d   = ccw_q ? (heading_q - STEP_ONE)
                                        : (heading_q + STEP_ONE);
                    remaining_d = remaining_q - STEP_ONE;
                    if (turn_count_q != CNT_MAX) begin
                        turn_count_d = turn_count_q + CNT_ONE;
                    end
                    if (remaining_q == STEP_ONE) begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
                // Abort is evaluated after the step update so a step that
                // completes on the same edge is kept, and the partial step
                // in progress is simply dropped.
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                    timer_d   = 8'd0;
                end
            end

            S_DONE: begin
                state_d   = S_IDLE;
                aborted_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clockc3 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            heading_q    <= '0;
            timer_q      <= 8'd0;
            remaining_q  <= '0;
            ccw_q        <= 1'b0;
            turn_count_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            heading_q    <= heading_d;
            timer_q      <= timer_d;
            remaining_q  <= remaining_d;
            ccw_q        <= ccw_d;
            turn_count_q <= turn_count_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_TURN);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign heading    = heading_q;
    assign turn_count = turn_count_q;

    generate
        if (N_DIR == 4) begin : g_code_4dir
            always_comb begin
                case (heading_q[1:0])
                    2'd0:    heading_code = 3'b001;
                    2'd1:    heading_code = 3'b011;
                    2'd2:    heading_code = 3'b100;
                    default: heading_code = 3'b010;
                endcase
            end
        end else begin : g_code_none
            assign heading_code = 3'b000;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_heading_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_heading_tracker
// Purpose  : Self-checking bench for heading_tracker. Two instances are
//            built: A (4 headings, 4 cycles/step, 8-bit count) and
//            B (8 headings, 2 cycles/step, 2-bit count). Commands are issued
//            to one instance at a time and every cycle of the command is
//            compared against a timeline computed from the command itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heading_tracker;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [2:0] cmd_steps;
    logic [2:0] cmd_heading;
    logic       abort;
    int         sel;

    logic       a_ready, a_busy, a_done, a_aborted;
    logic [1:0] a_heading;
    logic [2:0] a_code;
    logic [7:0] a_tc;
    logic       b_ready, b_busy, b_done, b_aborted;
    logic [2:0] b_heading;
    logic [2:0] b_code;
    logic [1:0] b_tc;

    logic       a_valid, b_valid, a_abort, b_abort;
    assign a_valid = cmd_valid & (sel == 0);
    assign b_valid = cmd_valid & (sel == 1);
    assign a_abort = abort & (sel == 0);
    assign b_abort = abort & (sel == 1);

    heading_tracker #(.N_DIR(4), .STEP_CYCLES(4), .CNT_W(8)) u_a (
        .clockc3(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps[1:0]), .cmd_heading(cmd_heading[1:0]),
        .abort(a_abort), .heading(a_heading), .heading_code(a_code),
        .busy(a_busy), .done(a_done), .aborted(a_aborted), .turn_count(a_tc)
    );

    heading_tracker #(.N_DIR(8), .STEP_CYCLES(2), .CNT_W(2)) u_b (
        .clockc3(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_heading(cmd_heading),
        .abort(b_abort), .heading(b_heading), .heading_code(b_code),
        .busy(b_busy), .done(b_done), .aborted(b_aborted), .turn_count(b_tc)
    );

    // Observation of whichever instance is selected
    logic       obs_ready, obs_busy, obs_done, obs_aborted;
    logic [2:0] obs_heading, obs_code;
    logic [7:0] obs_tc;
    assign obs_ready   = (sel == 0) ? a_ready   : b_ready;
    assign obs_busy    = (sel == 0) ? a_busy    : b_busy;
    assign obs_done    = (sel == 0) ? a_done    : b_done;
    assign obs_aborted = (sel == 0) ? a_aborted : b_aborted;
    assign obs_heading = (sel == 0) ? {1'b0, a_heading} : b_heading;
    assign obs_code    = (sel == 0) ? a_code    : b_code;
    assign obs_tc      = (sel == 0) ? a_tc      : {6'd0, b_tc};

    int n_vec = 0;
    int n_err = 0;
    int mh[2];   // model heading per instance
    int mtc[2];  // model turn count per instance

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_code(input int n, input int h);
        logic [2:0] tbl [4];
        tbl[0] = 3'b001; tbl[1] = 3'b011; tbl[2] = 3'b100; tbl[3] = 3'b010;
        if (n != 4) return 3'b000;
        return tbl[h % 4];
    endfunction

    // Issue one command to instance `which` and check every cycle from the
    // acceptance edge until the instance is back in IDLE. abort_at is the
    // edge (counted from acceptance) at which abort is high; -1 for none.
    task automatic do_cmd(input int which, input int op, input int steps, input int hd,
                          input int abort_at, input bit hold, input string tag);
        int n, sc, cmax, s, dir, end_e, ks, h0, tc0, exp_h, exp_tc, hde;
        bit ab, ld;
        n    = (which == 0) ? 4 : 8;
        sc   = (which == 0) ? 4 : 2;
        cmax = (which == 0) ? 255 : 3;
        hde  = hd % n;
        ld   = (op == 3);
        if (ld)           s = 0;
        else if (op == 2) s = n / 2;
        else              s = steps % n;
        dir = (op == 1) ? -1 : 1;
        if (s > 0 && abort_at >= 1 && abort_at <= s * sc) begin
            ab = 1'b1; end_e = abort_at;
        end else begin
            ab = 1'b0; end_e = s * sc;
        end
        h0  = mh[which];
        tc0 = mtc[which];
        exp_h = h0; exp_tc = tc0;

        @(negedge clk);
        sel = which;
        cmd_op = 2'(op); cmd_steps = 3'(steps); cmd_heading = 3'(hd);
        cmd_valid = 1'b1; abort = 1'b0;
        #1;
        n_vec++;
        if (obs_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready-before-accept got %b want 1", tag, obs_ready);
        end
        @(posedge clk);
        for (int j = 0; j <= end_e + 1; j++) begin
            @(negedge clk);
            ks = ld ? 0 : (((j < end_e) ? j : end_e) / sc);
            if (ks > s) ks = s;
            exp_h  = ld ? hde : (((h0 + dir * ks) % n) + n) % n;
            exp_tc = (tc0 + ks > cmax) ? cmax : tc0 + ks;
            n_vec += 6;
            if (obs_heading !== 3'(exp_h)) begin
                n_err++; $display("FAIL %s heading j=%0d got %0d want %0d", tag, j, obs_heading, exp_h);
            end
            if (obs_code !== exp_code(n, exp_h)) begin
                n_err++; $display("FAIL %s code j=%0d got %b want %b", tag, j, obs_code, exp_code(n, exp_h));
            end
            if (obs_busy !== (j < end_e)) begin
                n_err++; $display("FAIL %s busy j=%0d got %b want %b", tag, j, obs_busy, (j < end_e));
            end
            if (obs_done !== (j == end_e)) begin
                n_err++; $display("FAIL %s done j=%0d got %b want %b", tag, j, obs_done, (j == end_e));
            end
            if (obs_ready !== (j > end_e)) begin
                n_err++; $display("FAIL %s ready j=%0d got %b want %b", tag, j, obs_ready, (j > end_e));
            end
            if (obs_tc !== 8'(exp_tc)) begin
                n_err++; $display("FAIL %s turn_count j=%0d got %0d want %0d", tag, j, obs_tc, exp_tc);
            end
            if (j == end_e) begin
                n_vec++;
                if (obs_aborted !== ab) begin
                    n_err++; $display("FAIL %s aborted got %b want %b", tag, obs_aborted, ab);
                end
            end
            // Optionally keep a (random) request up while not in IDLE; it
            // must be ignored. Abort is also raised on the DONE edge, where
            // it must have no effect.
            cmd_valid = hold && (j < end_e);
            if (hold) begin
                cmd_op = 2'($urandom); cmd_steps = 3'($urandom); cmd_heading = 3'($urandom);
            end
            abort = (j <= end_e) && ((j + 1 == abort_at) || (j == end_e));
            @(posedge clk);
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        mh[which]  = exp_h;
        mtc[which] = exp_tc;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mh[0] = 0; mh[1] = 0; mtc[0] = 0; mtc[1] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; sel = 0;
        cmd_op = 2'd0; cmd_steps = 3'd0; cmd_heading = 3'd0;
        repeat (2) @(posedge clk);
        #2;
        n_vec += 6;
        if (a_heading !== 2'd0)    begin n_err++; $display("FAIL reset a_heading got %0d want 0", a_heading); end
        if (a_code !== 3'b001)     begin n_err++; $display("FAIL reset a_code got %b want 001", a_code); end
        if (b_code !== 3'b000)     begin n_err++; $display("FAIL reset b_code got %b want 000", b_code); end
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_aborted !== 1'b0) begin
            n_err++; $display("FAIL reset a_flags got %b%b%b want 000", a_busy, a_done, a_aborted);
        end
        if (a_tc !== 8'd0 || b_tc !== 2'd0) begin
            n_err++; $display("FAIL reset turn_count got %0d/%0d want 0/0", a_tc, b_tc);
        end
        if (b_heading !== 3'd0)    begin n_err++; $display("FAIL reset b_heading got %0d want 0", b_heading); end
        @(negedge clk);
        reset = 1'b0;
        mh[0] = 0; mh[1] = 0; mtc[0] = 0; mtc[1] = 0;
    endtask

    task automatic test_cw_single();
        do_cmd(0, 0, 1, 0, -1, 1'b0, "cw1");
        n_vec += 3;
        if (a_heading !== 2'd1)  begin n_err++; $display("FAIL cw1_final heading got %0d want 1", a_heading); end
        if (a_code !== 3'b011)   begin n_err++; $display("FAIL cw1_final code got %b want 011", a_code); end
        if (a_tc !== 8'd1)       begin n_err++; $display("FAIL cw1_final turn_count got %0d want 1", a_tc); end
    endtask

    task automatic test_ccw_reverse();
        pulse_reset();
        do_cmd(0, 1, 1, 0, -1, 1'b0, "ccw1");
        n_vec += 2;
        if (a_heading !== 2'd3)  begin n_err++; $display("FAIL ccw1_final heading got %0d want 3", a_heading); end
        if (a_code !== 3'b010)   begin n_err++; $display("FAIL ccw1_final code got %b want 010", a_code); end
        do_cmd(0, 2, 0, 0, -1, 1'b0, "rev");
        n_vec += 2;
        if (a_heading !== 2'd1)  begin n_err++; $display("FAIL rev_final heading got %0d want 1", a_heading); end
        if (a_tc !== 8'd3)       begin n_err++; $display("FAIL rev_final turn_count got %0d want 3", a_tc); end
    endtask

    task automatic test_abort();
        int h, tc;
        h = mh[0]; tc = mtc[0];
        do_cmd(0, 0, 3, 0, 6, 1'b0, "abort6");
        n_vec += 2;
        if (a_heading !== 2'((h + 1) % 4)) begin
            n_err++; $display("FAIL abort6_final heading got %0d want %0d", a_heading, (h + 1) % 4);
        end
        if (a_tc !== 8'(tc + 1)) begin
            n_err++; $display("FAIL abort6_final turn_count got %0d want %0d", a_tc, tc + 1);
        end
        // abort coinciding with the final step edge
        do_cmd(0, 1, 2, 0, 8, 1'b0, "abort_last");
        // abort coinciding with an intermediate step edge
        do_cmd(0, 0, 3, 0, 4, 1'b0, "abort_mid");
        // abort while idle does nothing
        h = mh[0];
        @(negedge clk);
        sel = 0; abort = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_heading !== 2'(h)) begin
            n_err++; $display("FAIL abort_idle got busy=%b done=%b heading=%0d want 0 0 %0d",
                              a_busy, a_done, a_heading, h);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) do_cmd(1, 0, 1, 0, -1, 1'b1, "sat");
        n_vec++;
        if (b_tc !== 2'd3) begin n_err++; $display("FAIL sat_final turn_count got %0d want 3", b_tc); end
    endtask

    task automatic test_reset_mid_turn();
        @(negedge clk);
        sel = 0; cmd_op = 2'd0; cmd_steps = 3'd3; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec += 2;
        if (a_heading !== 2'd0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_err++; $display("FAIL midreset_async got heading=%0d busy=%b done=%b want 0 0 0",
                              a_heading, a_busy, a_done);
        end
        if (a_tc !== 8'd0 || b_tc !== 2'd0) begin
            n_err++; $display("FAIL midreset_count got %0d/%0d want 0/0", a_tc, b_tc);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_held got done=%b busy=%b want 0 0", a_done, a_busy);
        end
        reset = 1'b0;
        cmd_op = 2'd3; cmd_heading = 3'd2; cmd_valid = 1'b1;
        #1;
        n_vec++;
        if (a_ready !== 1'b1) begin n_err++; $display("FAIL postreset_ready got %b want 1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_vec++;
        if (a_done !== 1'b1 || a_heading !== 2'd2) begin
            n_err++; $display("FAIL postreset_accept got done=%b heading=%0d want 1 2", a_done, a_heading);
        end
        @(posedge clk);
        mh[0] = 2; mtc[0] = 0; mh[1] = 0; mtc[1] = 0;
    endtask

    task automatic test_n8_wrap();
        do_cmd(1, 3, 0, 7, -1, 1'b0, "ld7");
        do_cmd(1, 0, 3, 0, -1, 1'b0, "n8cw3");
        n_vec += 2;
        if (b_heading !== 3'd2) begin n_err++; $display("FAIL n8_final heading got %0d want 2", b_heading); end
        if (b_code !== 3'b000)  begin n_err++; $display("FAIL n8_final code got %b want 000", b_code); end
        do_cmd(1, 1, 5, 0, -1, 1'b0, "n8ccw5");
        do_cmd(1, 0, 0, 0, -1, 1'b0, "n8zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : -1,
                   1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_cw_single();
        test_ccw_reverse();
        test_abort();
        test_saturation();
        test_reset_mid_turn();
        test_n8_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
